// File: rtl/cpu_core_ctrl_pkg.sv
// cpu_core_ctrl_pkg: shared types and helpers for the per-core run/reset
// sequencer.
//   core_state_t : per-core sequencer state (OFF/HOLD/RUN/DRAIN)
//   core_out_t   : decoded (rb, halt, run) output bundle for one core
//   cnt_width()  : width of the shared hold/drain counter
//   decode_out() : state -> output bundle
package cpu_core_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } core_state_t;

   typedef struct packed {
      logic rb;
      logic halt;
      logic run;
   } core_out_t;

   // One counter serves both the reset hold and the drain timeout, so it is
   // sized for the larger of the two terminal counts.
   function automatic int cnt_width(input int hold, input int tmo);
      int m;
      m = (hold > tmo) ? hold : tmo;
      return $clog2(m + 1);
   endfunction

   function automatic core_out_t decode_out(input core_state_t st);
      core_out_t o;
      case (st)
         ST_OFF:   o = '{rb: 1'b0, halt: 1'b1, run: 1'b0};
         ST_HOLD:  o = '{rb: 1'b0, halt: 1'b0, run: 1'b0};
         ST_RUN:   o = '{rb: 1'b1, halt: 1'b0, run: 1'b1};
         ST_DRAIN: o = '{rb: 1'b1, halt: 1'b1, run: 1'b0};
         default:  o = '{rb: 1'b0, halt: 1'b1, run: 1'b0};
      endcase
      return o;
   endfunction

endpackage

// File: rtl/cpu_core_seq.sv
// cpu_core_seq: run/reset sequencer for a single core.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable for this core
//   idle       : core has no bus cycle in progress
//   core_rb    : active-low reset to the core
//   core_halt  : halt request (finish current bus cycle, start no new one)
//   core_run   : sequencer is in RUN
//   core_tmo   : sticky, last drain ended by timeout (cleared on HOLD entry)
// Outputs decode only from the state and tmo registers.
module cpu_core_seq
   import cpu_core_ctrl_pkg::*;
#(
   parameter int RST_HOLD = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic idle,
   output logic core_rb,
   output logic core_halt,
   output logic core_run,
   output logic core_tmo
);

   localparam int CW = cnt_width(RST_HOLD, TIMEOUT);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

   core_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
   core_out_t     outs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // The terminal compares always leave HOLD/DRAIN before the counter could
   // reach its maximum, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_OFF: begin
            if (en) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               tmo_d   = 1'b0;
            end
         end
         ST_HOLD: begin
            // Dropping enable wins over reaching the hold count.
            if (!en) begin
               state_d = ST_OFF;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            // Enable is ignored here: a drain always runs to OFF so the core
            // gets a clean reset before it is started again.
            if (idle) begin
               state_d = ST_OFF;
            end else if (cnt_q == TMO_LAST) begin
               state_d = ST_OFF;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   assign outs      = decode_out(state_q);
   assign core_rb   = outs.rb;
   assign core_halt = outs.halt;
   assign core_run  = outs.run;
   assign core_tmo  = tmo_q;

endmodule

// File: rtl/cpu_core_ctrl.sv
// cpu_core_ctrl: per-core run/reset sequencer driven by the CPU control word.
//   i_ck        : clock
//   i_rb        : asynchronous active-low reset
//   i_cpu_regs  : control word, bit n enables core n (bits >= N_CORES ignored)
//   i_core_idle : core n has no bus cycle in progress
//   o_core_rb   : per-core active-low reset
//   o_core_halt : per-core halt request
//   o_core_run  : core n is in RUN
//   o_core_tmo  : sticky, last drain of core n ended by timeout
module cpu_core_ctrl
   import cpu_core_ctrl_pkg::*;
#(
   parameter int N_CORES  = 2,
   parameter int RST_HOLD = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic               i_ck,
   input  logic               i_rb,
   input  logic [31:0]        i_cpu_regs,
   input  logic [N_CORES-1:0] i_core_idle,
   output logic [N_CORES-1:0] o_core_rb,
   output logic [N_CORES-1:0] o_core_halt,
   output logic [N_CORES-1:0] o_core_run,
   output logic [N_CORES-1:0] o_core_tmo
);

   // Control bits above the core count have no consumer.
   logic unused_regs;
   assign unused_regs = ^i_cpu_regs;

   for (genvar g = 0; g < N_CORES; g++) begin : g_core
      cpu_core_seq #(
         .RST_HOLD (RST_HOLD),
         .TIMEOUT  (TIMEOUT)
      ) u_seq (
         .clk       (i_ck),
         .rst_n     (i_rb),
         .en        (i_cpu_regs[g]),
         .idle      (i_core_idle[g]),
         .core_rb   (o_core_rb[g]),
         .core_halt (o_core_halt[g]),
         .core_run  (o_core_run[g]),
         .core_tmo  (o_core_tmo[g])
      );
   end

endmodule

// File: tb/tb_cpu_core_ctrl.sv
// tb_cpu_core_ctrl: directed scenarios followed by random enable/idle traffic,
// all checked against a countdown-based reference model of each core.
module tb_cpu_core_ctrl;

   localparam int NC  = 2;
   localparam int RH  = 4;
   localparam int TMO = 8;

   logic          i_ck = 1'b0;
   logic          i_rb;
   logic [31:0]   i_cpu_regs;
   logic [NC-1:0] i_core_idle;
   logic [NC-1:0] o_core_rb, o_core_halt, o_core_run, o_core_tmo;

   int checks = 0;
   int errors = 0;

   // Reference model: a core is powered when m_rb=1; halt marks OFF/DRAIN.
   // HOLD and DRAIN are tracked as remaining-cycle countdowns.
   logic [NC-1:0] m_rb, m_halt, m_tmo;
   int            m_hold [NC];
   int            m_drain[NC];

   cpu_core_ctrl #(.N_CORES(NC), .RST_HOLD(RH), .TIMEOUT(TMO)) dut (
      .i_ck        (i_ck),
      .i_rb        (i_rb),
      .i_cpu_regs  (i_cpu_regs),
      .i_core_idle (i_core_idle),
      .o_core_rb   (o_core_rb),
      .o_core_halt (o_core_halt),
      .o_core_run  (o_core_run),
      .o_core_tmo  (o_core_tmo)
   );

   always #5 i_ck = ~i_ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rb   = '0;
      m_halt = '1;
      m_tmo  = '0;
      for (int n = 0; n < NC; n++) begin
         m_hold[n]  = 0;
         m_drain[n] = 0;
      end
   endtask

   task automatic model_step();
      for (int n = 0; n < NC; n++) begin
         logic en;
         en = i_cpu_regs[n];
         if (!m_rb[n] && m_halt[n]) begin            // off
            if (en) begin
               m_halt[n] = 1'b0;
               m_hold[n] = RH;
               m_tmo[n]  = 1'b0;
            end
         end else if (!m_rb[n]) begin                // holding reset
            if (!en) m_halt[n] = 1'b1;
            else begin
               m_hold[n]--;
               if (m_hold[n] == 0) m_rb[n] = 1'b1;
            end
         end else if (!m_halt[n]) begin              // running
            if (!en) begin
               m_halt[n]  = 1'b1;
               m_drain[n] = TMO;
            end
         end else begin                              // draining
            if (i_core_idle[n]) m_rb[n] = 1'b0;
            else begin
               m_drain[n]--;
               if (m_drain[n] == 0) begin
                  m_rb[n]  = 1'b0;
                  m_tmo[n] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_rb"},   32'(o_core_rb),   32'(m_rb));
      chk({tag, "_halt"}, 32'(o_core_halt), 32'(m_halt));
      chk({tag, "_run"},  32'(o_core_run),  32'(m_rb & ~m_halt));
      chk({tag, "_tmo"},  32'(o_core_tmo),  32'(m_tmo));
   endtask

   // One clock edge: advance the model with the inputs seen at the edge,
   // then compare a little after the edge.
   task automatic tick(input string tag);
      @(posedge i_ck);
      model_step();
      #2;
      check_model(tag);
   endtask

   // Enable bits with random garbage in the ignored upper bits.
   task automatic set_en(input logic [NC-1:0] en);
      i_cpu_regs = ($urandom() & 32'hFFFF_FFFC) | 32'(en);
   endtask

   initial begin
      int edges;
      int drain_cyc;

      // ---- 1: reset, then core0 enabled -------------------------------
      i_rb        = 1'b0;
      i_cpu_regs  = 32'h1;
      i_core_idle = 2'b11;
      model_reset();
      #12;
      chk("rst_rb",   32'(o_core_rb),   32'h0);
      chk("rst_halt", 32'(o_core_halt), 32'h3);
      chk("rst_run",  32'(o_core_run),  32'h0);
      chk("rst_tmo",  32'(o_core_tmo),  32'h0);
      #11 i_rb = 1'b1;                              // mid-cycle release
      edges = 0;
      while (o_core_rb[0] !== 1'b1 && edges < 20) begin
         tick("t1");
         edges++;
         chk("t1_core1_rb",   32'(o_core_rb[1]),   32'h0);
         chk("t1_core1_halt", 32'(o_core_halt[1]), 32'h1);
      end
      chk("t1_release_edges", edges, 5);
      chk("t1_run0", 32'(o_core_run[0]), 32'h1);

      // ---- 2: disable, idle arrives after 4 drain cycles --------------
      i_core_idle = 2'b00;
      i_cpu_regs  = 32'h0;
      drain_cyc   = 0;
      for (int i = 0; i < 4; i++) begin
         tick("t2");
         if (o_core_rb[0] === 1'b1 && o_core_halt[0] === 1'b1) drain_cyc++;
      end
      chk("t2_drain_cycles", drain_cyc, 4);
      i_core_idle[0] = 1'b1;
      tick("t2");
      chk("t2_rb_fall", 32'(o_core_rb[0]),  32'h0);
      chk("t2_tmo",     32'(o_core_tmo[0]), 32'h0);

      // ---- 3: drain timeout, then re-enable ---------------------------
      i_core_idle = 2'b00;
      i_cpu_regs  = 32'h1;
      for (int i = 0; i < 5; i++) tick("t3_up");
      chk("t3_running", 32'(o_core_rb[0]), 32'h1);
      i_cpu_regs = 32'h0;
      edges = 0;
      do begin
         tick("t3_drain");
         edges++;
      end while (o_core_rb[0] === 1'b1 && edges < 30);
      chk("t3_timeout_edges", edges - 1, TMO);
      chk("t3_tmo_set", 32'(o_core_tmo[0]), 32'h1);
      i_cpu_regs = 32'h1;
      tick("t3_reen");
      chk("t3_tmo_clr", 32'(o_core_tmo[0]), 32'h0);
      for (int i = 0; i < 3; i++) tick("t3_hold");
      chk("t3_still_held", 32'(o_core_rb[0]), 32'h0);
      tick("t3_rel");
      chk("t3_rb_rise", 32'(o_core_rb[0]), 32'h1);

      // ---- 4: core1 enable dropped during HOLD ------------------------
      set_en(2'b11);
      tick("t4");
      set_en(2'b11);
      tick("t4");
      set_en(2'b01);
      tick("t4");
      chk("t4_core1_off", 32'(o_core_halt[1]), 32'h1);
      for (int i = 0; i < 6; i++) begin
         set_en(2'b01);
         tick("t4");
         chk("t4_core1_rb", 32'(o_core_rb[1]), 32'h0);
         chk("t4_core0_rb", 32'(o_core_rb[0]), 32'h1);
      end

      // ---- 5: re-enable during drain is ignored until OFF -------------
      i_core_idle = 2'b00;
      set_en(2'b00);
      tick("t5");
      tick("t5");
      set_en(2'b01);
      tick("t5");
      tick("t5");
      i_core_idle[0] = 1'b1;
      tick("t5");
      chk("t5_off_rb",   32'(o_core_rb[0]),   32'h0);
      chk("t5_off_halt", 32'(o_core_halt[0]), 32'h1);
      i_core_idle[0] = 1'b0;
      tick("t5");
      chk("t5_hold_halt", 32'(o_core_halt[0]), 32'h0);
      for (int i = 0; i < 3; i++) tick("t5");
      chk("t5_hold_rb", 32'(o_core_rb[0]), 32'h0);
      tick("t5");
      chk("t5_run", 32'(o_core_run[0]), 32'h1);

      // ---- 6: asynchronous reset mid-cycle ----------------------------
      set_en(2'b11);
      tick("t6");
      chk("t6_pre_rb", 32'(o_core_rb), 32'h1);
      #2 i_rb = 1'b0;                               // between edges
      #1;
      model_reset();
      chk("t6_rb",   32'(o_core_rb),   32'h0);
      chk("t6_halt", 32'(o_core_halt), 32'h3);
      chk("t6_run",  32'(o_core_run),  32'h0);
      chk("t6_tmo",  32'(o_core_tmo),  32'h0);
      #14 i_rb = 1'b1;

      // ---- random traffic ---------------------------------------------
      begin
         logic [NC-1:0] en;
         en = 2'b11;
         for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < NC; n++)
               if ($urandom_range(0, 9) == 0) en[n] = ~en[n];
            set_en(en);
            for (int n = 0; n < NC; n++)
               i_core_idle[n] = ($urandom_range(0, 5) == 0);
            if (cyc == 200) begin
               #3 i_rb = 1'b0;
               #1;
               model_reset();
               check_model("rnd_arst");
               #13 i_rb = 1'b1;
            end
            tick("rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
